psum_accumulator: RTL and testbench

Upstream neighbour of the ppu. Accumulates 16-lane partial-sum rows from the PE array over one or more K-passes into a 16×16 tile of 24-bit signed accumulators. After the final pass it emits a one-cycle ppu start pulse, then streams the 16 accumulated rows, one row per cycle, in exactly the order the ppu consumes them on its accumulator-data input.

---
 rtl/acc_pkg.sv | 19 +
 rtl/acc_sat_add.sv | 31 +++
 rtl/psum_accumulator.sv | 138 +++++++++++++
 tb/tb_psum_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared widths, saturation limits and control states for the psum accumulator.
package acc_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned PSUM_W = 20;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned ROW_W  = $clog2(ROWS);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// One accumulator lane: overwrite with sign-extended psum, or saturating add.
module acc_sat_add
  import acc_pkg::*;
(
  input  logic [PSUM_W-1:0] psum,
  input  logic [ACC_W-1:0]  old,
  input  logic              overwrite,
  output logic [ACC_W-1:0]  result_c,
  output logic              sat_c
);

  logic [ACC_W:0] psum_ext;
  logic [ACC_W:0] old_ext;
  logic [ACC_W:0] sum;

  always_comb begin
    psum_ext = {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum};
    old_ext  = {old[ACC_W-1], old};
    sum      = old_ext + psum_ext;
    result_c = sum[ACC_W-1:0];
    sat_c    = 1'b0;
    if (overwrite) begin
      result_c = psum_ext[ACC_W-1:0];
    end else if (sum[ACC_W] != sum[ACC_W-1]) begin
      // One guard bit suffices: the true sum left the ACC_W range iff it disagrees with bit ACC_W-1.
      sat_c    = 1'b1;
      result_c = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates K-pass partial-sum rows into a 16x16 tile and drains it to the ppu.
module psum_accumulator
  import acc_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_psum_valid,
  output logic                    o_psum_ready,
  input  logic [PSUM_W*LANES-1:0] i_psum_data,
  input  logic                    i_psum_first,
  input  logic                    i_psum_last,
  output logic                    o_ppu_start,
  output logic                    o_acc_valid,
  output logic [ACC_W*LANES-1:0]  o_acc_data,
  output logic                    o_tile_done,
  output logic                    o_sat_flag
);

  state_t                   state, next_state;
  logic [ROW_W-1:0]         row_cnt, row_cnt_n;
  logic [ROW_W-1:0]         drain_cnt, drain_cnt_n;
  logic                     first_q, first_n;
  logic                     last_q, last_n;
  logic                     ppu_start_n, acc_valid_n, tile_done_n, sat_flag_n;
  logic [ACC_W*LANES-1:0]   acc_data_n;

  logic [ACC_W*LANES-1:0]   bank [ROWS];
  logic                     bank_we;
  logic [ROW_W-1:0]         rd_addr;
  logic [ACC_W*LANES-1:0]   rd_row;
  logic [ACC_W*LANES-1:0]   wr_row;
  logic [LANES-1:0]         sat_vec;
  logic                     accept;
  logic                     pass_first;
  logic                     pass_last;

  assign o_psum_ready = (state == ACCUM);
  assign accept       = i_psum_valid && o_psum_ready;

  // Pass flags are live on the row-0 beat and latched for the rest of the pass.
  assign pass_first = (row_cnt == '0) ? i_psum_first : first_q;
  assign pass_last  = (row_cnt == '0) ? i_psum_last  : last_q;

  // Single read port shared by read-modify-write in ACCUM and the drain look-ahead.
  assign rd_addr = (state == ACCUM) ? row_cnt :
                   (state == START) ? '0 : drain_cnt + ROW_W'(1);
  assign rd_row  = bank[rd_addr];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acc_sat_add u_lane (
      .psum      (i_psum_data[k*PSUM_W +: PSUM_W]),
      .old       (rd_row[k*ACC_W +: ACC_W]),
      .overwrite (pass_first),
      .result_c  (wr_row[k*ACC_W +: ACC_W]),
      .sat_c     (sat_vec[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (bank_we) bank[row_cnt] <= wr_row;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ACCUM;
      row_cnt     <= '0;
      drain_cnt   <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      o_ppu_start <= 1'b0;
      o_acc_valid <= 1'b0;
      o_acc_data  <= '0;
      o_tile_done <= 1'b0;
      o_sat_flag  <= 1'b0;
    end else begin
      state       <= next_state;
      row_cnt     <= row_cnt_n;
      drain_cnt   <= drain_cnt_n;
      first_q     <= first_n;
      last_q      <= last_n;
      o_ppu_start <= ppu_start_n;
      o_acc_valid <= acc_valid_n;
      o_acc_data  <= acc_data_n;
      o_tile_done <= tile_done_n;
      o_sat_flag  <= sat_flag_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    next_state  = state;
    row_cnt_n   = row_cnt;
    drain_cnt_n = drain_cnt;
    first_n     = first_q;
    last_n      = last_q;
    ppu_start_n = 1'b0;
    acc_valid_n = 1'b0;
    acc_data_n  = o_acc_data;
    tile_done_n = 1'b0;
    sat_flag_n  = o_sat_flag;
    bank_we     = 1'b0;

    case (state)
      ACCUM: begin
        if (accept) begin
          bank_we   = 1'b1;
          row_cnt_n = row_cnt + ROW_W'(1);
          first_n   = pass_first;
          last_n    = pass_last;
          if (|sat_vec) sat_flag_n = 1'b1;
          if (row_cnt == ROW_W'(ROWS-1) && pass_last) begin
            next_state  = START;
            ppu_start_n = 1'b1;
          end
        end
      end
      START: begin
        next_state  = DRAIN;
        drain_cnt_n = '0;
        acc_valid_n = 1'b1;
        acc_data_n  = rd_row;
      end
      DRAIN: begin
        if (drain_cnt == ROW_W'(ROWS-1)) begin
          next_state = ACCUM;
          sat_flag_n = 1'b0;
        end else begin
          drain_cnt_n = drain_cnt + ROW_W'(1);
          acc_valid_n = 1'b1;
          acc_data_n  = rd_row;
          tile_done_n = (drain_cnt == ROW_W'(ROWS-2));
        end
      end
      default: next_state = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized self-checking bench for psum_accumulator against a pass-level model.
module tb_psum_accumulator;
  import acc_pkg::*;

  localparam int unsigned RW = ACC_W*LANES;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    psum_valid;
  logic                    psum_ready;
  logic [PSUM_W*LANES-1:0] psum_data;
  logic                    psum_first;
  logic                    psum_last;
  logic                    ppu_start;
  logic                    acc_valid;
  logic [RW-1:0]           acc_data;
  logic                    tile_done;
  logic                    sat_flag;

  int     checks   = 0;
  int     failures = 0;
  int     stim  [ROWS][LANES];
  longint model [ROWS][LANES];
  bit     model_sat;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_psum_valid (psum_valid),
    .o_psum_ready (psum_ready),
    .i_psum_data  (psum_data),
    .i_psum_first (psum_first),
    .i_psum_last  (psum_last),
    .o_ppu_start  (ppu_start),
    .o_acc_valid  (acc_valid),
    .o_acc_data   (acc_data),
    .o_tile_done  (tile_done),
    .o_sat_flag   (sat_flag)
  );

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    longint hi = (64'sd1 <<< (ACC_W-1)) - 1;
    longint lo = -(64'sd1 <<< (ACC_W-1));
    if (v > hi) begin model_sat = 1'b1; return hi; end
    if (v < lo) begin model_sat = 1'b1; return lo; end
    return v;
  endfunction

  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0] e;
    for (int k = 0; k < LANES; k++) e[k*ACC_W +: ACC_W] = ACC_W'(model[r][k]);
    return e;
  endfunction

  function automatic int rand_psum();
    int v = int'($urandom);
    return (v <<< (32-PSUM_W)) >>> (32-PSUM_W);
  endfunction

  task automatic fill_const(input int v);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < LANES; k++) stim[r][k] = v;
  endtask

  // Sends one K-pass; flags on rows 1..15 are junk, optionally forcing first=1 on force_row.
  task automatic send_pass(input bit pf, input bit pl, input bit hold, input int force_row);
    for (int r = 0; r < ROWS; r++) begin
      int waited = 0;
      psum_valid = 1'b1;
      for (int k = 0; k < LANES; k++) psum_data[k*PSUM_W +: PSUM_W] = PSUM_W'(stim[r][k]);
      psum_first = (r == 0) ? pf : 1'($urandom_range(0, 1));
      psum_last  = (r == 0) ? pl : 1'($urandom_range(0, 1));
      if (r == force_row) psum_first = 1'b1;
      while (!psum_ready && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!psum_ready) check("ready_timeout", 1, 0);
      @(posedge clk); #1;
      for (int k = 0; k < LANES; k++)
        model[r][k] = pf ? longint'(stim[r][k]) : clamp(model[r][k] + longint'(stim[r][k]));
    end
    if (hold) begin
      for (int k = 0; k < LANES; k++) psum_data[k*PSUM_W +: PSUM_W] = PSUM_W'(7);
      psum_first = 1'b1;
      psum_last  = 1'b1;
    end else begin
      psum_valid = 1'b0;
    end
  endtask

  // Entered in cycle T+1 after the final row-15 beat; walks the 17 dead cycles.
  task automatic check_drain(input string tag);
    check({tag, "_start"}, RW'(ppu_start), RW'(1));
    check({tag, "_start_rdy"}, RW'(psum_ready), RW'(0));
    check({tag, "_start_val"}, RW'(acc_valid), RW'(0));
    for (int d = 0; d < ROWS; d++) begin
      @(posedge clk); #1;
      check($sformatf("%s_row%0d", tag, d), acc_data, exp_row(d));
      check($sformatf("%s_ctl%0d", tag, d),
            RW'({acc_valid, psum_ready, ppu_start, tile_done, sat_flag}),
            RW'({1'b1, 1'b0, 1'b0, (d == ROWS-1), model_sat}));
    end
    @(posedge clk); #1;
    check({tag, "_post_ctl"}, RW'({acc_valid, psum_ready, ppu_start, tile_done, sat_flag}),
          RW'(5'b01000));
    check({tag, "_post_hold"}, acc_data, exp_row(ROWS-1));
    model_sat = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    psum_valid = 1'b0;
    psum_data  = '0;
    psum_first = 1'b0;
    psum_last  = 1'b0;
    model_sat  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", RW'({acc_valid, psum_ready, ppu_start, tile_done, sat_flag}), RW'(5'b01000));
    check("reset_data", acc_data, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single pass, lane value r*16+k.
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < LANES; k++) stim[r][k] = r*16 + k;
    send_pass(1, 1, 0, -1);
    check_drain("single");

    // Four passes of +3.
    fill_const(3);
    for (int p = 0; p < 4; p++) send_pass(p == 0, p == 3, 0, -1);
    check_drain("four");

    // Positive then negative saturation over 17 passes.
    fill_const((1 << (PSUM_W-1)) - 1);
    for (int p = 0; p < 17; p++) send_pass(p == 0, p == 16, 0, -1);
    check("sat_pos_lane", RW'(model[0][0]), RW'(8388607));
    check_drain("satpos");
    fill_const(-(1 << (PSUM_W-1)));
    for (int p = 0; p < 17; p++) send_pass(p == 0, p == 16, 0, -1);
    check("sat_neg_lane", RW'(ACC_W'(model[3][5])), RW'(ACC_W'(-8388608)));
    check_drain("satneg");

    // Backpressure: next tile's row 0 (value 7) held across the drain.
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < LANES; k++) stim[r][k] = rand_psum();
    send_pass(1, 1, 1, -1);
    check_drain("bp_a");
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < LANES; k++) stim[r][k] = (r == 0) ? 7 : rand_psum();
    send_pass(1, 1, 0, -1);
    check("bp_row0", RW'(model[0][9]), RW'(7));
    check_drain("bp_b");

    // Stray first=1 on row 5 of a non-first pass must be ignored.
    fill_const(2);
    send_pass(1, 0, 0, -1);
    fill_const(1);
    send_pass(0, 1, 0, 5);
    check("flag_model5", RW'(model[5][0]), RW'(3));
    check_drain("flag");

    // Random multi-pass tiles.
    for (int t = 0; t < 4; t++) begin
      int np = int'($urandom_range(1, 4));
      for (int p = 0; p < np; p++) begin
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < LANES; k++) stim[r][k] = rand_psum();
        send_pass(p == 0, p == np-1, 0, -1);
      end
      check_drain($sformatf("rand%0d", t));
    end

    // Asynchronous reset while drain row 7 is presented.
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < LANES; k++) stim[r][k] = rand_psum();
    send_pass(1, 1, 0, -1);
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("rst_pre_row7", acc_data, exp_row(7));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ctl", RW'({acc_valid, psum_ready, ppu_start, tile_done, sat_flag}), RW'(5'b01000));
    check("rst_mid_data", acc_data, '0);
    @(negedge clk) rst = 1'b0;
    model_sat = 1'b0;
    @(posedge clk); #1;
    check("rst_after_rdy", RW'(psum_ready), RW'(1));
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < LANES; k++) stim[r][k] = rand_psum();
    send_pass(1, 1, 0, -1);
    check_drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
